// File: rtl/accelerator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accelerator_pkg
// Brief    : Shared types and constants for the core/VLSU data-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package accelerator_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_VLSU = 1'b1
    } req_id_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

endpackage
`default_nettype wire

// File: rtl/obi_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : obi_rsp_fifo
// Brief    : Small circular FIFO that remembers which requester owns each
//            outstanding response, with occupancy count and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module obi_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Fullness is judged before any same-cycle pop, so a full FIFO never accepts a push.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/obi_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_data_arbiter
// Brief    : Round-robin OBI arbiter sharing one data port between the scalar
//            core and the vector LSU, with in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
module obi_data_arbiter
    import accelerator_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        n_reset,

    input  logic        core_data_req_i,
    input  logic        core_data_we_i,
    input  logic [31:0] core_data_addr_i,
    input  logic [31:0] core_data_wdata_i,
    input  logic [3:0]  core_data_be_i,
    output logic        core_data_gnt_o,
    output logic        core_data_rvalid_o,
    output logic [31:0] core_data_rdata_o,

    input  logic        vlsu_data_req_i,
    input  logic        vlsu_data_we_i,
    input  logic [31:0] vlsu_data_addr_i,
    input  logic [31:0] vlsu_data_wdata_i,
    input  logic [3:0]  vlsu_data_be_i,
    output logic        vlsu_data_gnt_o,
    output logic        vlsu_data_rvalid_o,
    output logic [31:0] vlsu_data_rdata_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_be_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,

    output logic        spurious_rsp_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       r_state;
    req_id_e          r_owner;
    req_id_e          r_last;

    logic             w_sel_valid;
    req_id_e          w_sel_id;
    logic             w_issue;
    logic             w_handshake;
    logic             w_rsp_fire;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_head_raw;
    req_id_e          w_head_id;
    logic [CNT_W-1:0] w_fifo_count;

    // LOCKED keeps the owner regardless of the other requester to honour request stability.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = REQ_CORE;
        if (r_state == LOCKED) begin
            w_sel_valid = 1'b1;
            w_sel_id    = r_owner;
        end else if (core_data_req_i && vlsu_data_req_i) begin
            w_sel_valid = 1'b1;
            w_sel_id    = (r_last == REQ_CORE) ? REQ_VLSU : REQ_CORE;
        end else if (core_data_req_i) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_CORE;
        end else if (vlsu_data_req_i) begin
            w_sel_valid = 1'b1;
            w_sel_id    = REQ_VLSU;
        end
    end

    assign w_issue = n_reset & w_sel_valid & ~w_fifo_full;

    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        data_be_o    = '0;
        if (w_issue) begin
            if (w_sel_id == REQ_CORE) begin
                data_req_o   = core_data_req_i;
                data_we_o    = core_data_we_i;
                data_addr_o  = core_data_addr_i;
                data_wdata_o = core_data_wdata_i;
                data_be_o    = core_data_be_i;
            end else begin
                data_req_o   = vlsu_data_req_i;
                data_we_o    = vlsu_data_we_i;
                data_addr_o  = vlsu_data_addr_i;
                data_wdata_o = vlsu_data_wdata_i;
                data_be_o    = vlsu_data_be_i;
            end
        end
    end

    assign w_handshake     = data_req_o & data_gnt_i;
    assign core_data_gnt_o = w_handshake & (w_sel_id == REQ_CORE);
    assign vlsu_data_gnt_o = w_handshake & (w_sel_id == REQ_VLSU);

    assign w_head_id          = req_id_e'(w_head_raw);
    assign w_rsp_fire         = n_reset & data_rvalid_i & ~w_fifo_empty;
    assign core_data_rvalid_o = w_rsp_fire & (w_head_id == REQ_CORE);
    assign vlsu_data_rvalid_o = w_rsp_fire & (w_head_id == REQ_VLSU);
    assign spurious_rsp_o     = n_reset & data_rvalid_i & w_fifo_empty;

    assign core_data_rdata_o = data_rdata_i;
    assign vlsu_data_rdata_o = data_rdata_i;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ARB;
            r_owner <= REQ_CORE;
            r_last  <= REQ_VLSU;
        end else begin
            if (w_handshake) begin
                r_last <= w_sel_id;
            end
            case (r_state)
                ARB: begin
                    if (data_req_o && !data_gnt_i) begin
                        r_state <= LOCKED;
                        r_owner <= w_sel_id;
                    end
                end
                LOCKED: begin
                    if (w_handshake) begin
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    obi_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_rsp_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (w_handshake),
        .push_data (w_sel_id),
        .pop       (w_rsp_fire),
        .head_data (w_head_raw),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_comb begin
        assert (w_fifo_count <= CNT_W'(MAX_OUTSTANDING));
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_data_arbiter
// Brief    : Self-checking bench for obi_data_arbiter: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_data_arbiter;

    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        core_data_req_i = 1'b0, core_data_we_i = 1'b0;
    logic [31:0] core_data_addr_i = '0, core_data_wdata_i = '0;
    logic [3:0]  core_data_be_i = 4'hF;
    logic        core_data_gnt_o, core_data_rvalid_o;
    logic [31:0] core_data_rdata_o;
    logic        vlsu_data_req_i = 1'b0, vlsu_data_we_i = 1'b0;
    logic [31:0] vlsu_data_addr_i = '0, vlsu_data_wdata_i = '0;
    logic [3:0]  vlsu_data_be_i = 4'hF;
    logic        vlsu_data_gnt_o, vlsu_data_rvalid_o;
    logic [31:0] vlsu_data_rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'h1234_5678;
    logic        spurious_rsp_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of requester IDs awaiting a response (0 = core, 1 = vlsu),
    // the requester whose unaccepted request is being held, and who won last.
    bit q[$];
    bit m_locked = 1'b0;
    bit m_owner  = 1'b0;
    bit m_last   = 1'b1;
    bit e_cg = 1'b0, e_vg = 1'b0;

    obi_data_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk                (clk),
        .n_reset            (n_reset),
        .core_data_req_i    (core_data_req_i),
        .core_data_we_i     (core_data_we_i),
        .core_data_addr_i   (core_data_addr_i),
        .core_data_wdata_i  (core_data_wdata_i),
        .core_data_be_i     (core_data_be_i),
        .core_data_gnt_o    (core_data_gnt_o),
        .core_data_rvalid_o (core_data_rvalid_o),
        .core_data_rdata_o  (core_data_rdata_o),
        .vlsu_data_req_i    (vlsu_data_req_i),
        .vlsu_data_we_i     (vlsu_data_we_i),
        .vlsu_data_addr_i   (vlsu_data_addr_i),
        .vlsu_data_wdata_i  (vlsu_data_wdata_i),
        .vlsu_data_be_i     (vlsu_data_be_i),
        .vlsu_data_gnt_o    (vlsu_data_gnt_o),
        .vlsu_data_rvalid_o (vlsu_data_rvalid_o),
        .vlsu_data_rdata_o  (vlsu_data_rdata_o),
        .data_req_o         (data_req_o),
        .data_we_o          (data_we_o),
        .data_addr_o        (data_addr_o),
        .data_wdata_o       (data_wdata_o),
        .data_be_o          (data_be_o),
        .data_gnt_i         (data_gnt_i),
        .data_rvalid_i      (data_rvalid_i),
        .data_rdata_i       (data_rdata_i),
        .spurious_rsp_o     (spurious_rsp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          have, who, full, hs;
        bit          ereq, ewe, ecr, evr, esp;
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ebe;
        have = 0; who = 0; full = 0; hs = 0;
        ereq = 0; ewe = 0; ecr = 0; evr = 0; esp = 0;
        eaddr = '0; ewdata = '0; ebe = '0;
        if (!n_reset) begin
            q.delete();
            m_locked = 0; m_owner = 0; m_last = 1;
        end else begin
            full = (q.size() == MAXO);
            if (m_locked) begin
                have = 1; who = m_owner;
            end else if (core_data_req_i && vlsu_data_req_i) begin
                have = 1; who = ~m_last;
            end else if (core_data_req_i) begin
                have = 1; who = 0;
            end else if (vlsu_data_req_i) begin
                have = 1; who = 1;
            end
            if (have && !full) begin
                if (who == 0)
                    {ereq, ewe, eaddr, ebe, ewdata} = {core_data_req_i, core_data_we_i,
                        core_data_addr_i, core_data_be_i, core_data_wdata_i};
                else
                    {ereq, ewe, eaddr, ebe, ewdata} = {vlsu_data_req_i, vlsu_data_we_i,
                        vlsu_data_addr_i, vlsu_data_be_i, vlsu_data_wdata_i};
            end
            hs = ereq && data_gnt_i;
            if (data_rvalid_i) begin
                if (q.size() > 0) begin
                    if (q[0] == 0) ecr = 1; else evr = 1;
                end else begin
                    esp = 1;
                end
            end
        end
        e_cg = hs && (who == 0);
        e_vg = hs && (who == 1);
        chk("m_req",    32'(data_req_o),         32'(ereq));
        chk("m_we",     32'(data_we_o),          32'(ewe));
        chk("m_addr",   data_addr_o,             eaddr);
        chk("m_be",     32'(data_be_o),          32'(ebe));
        chk("m_wdata",  data_wdata_o,            ewdata);
        chk("m_cgnt",   32'(core_data_gnt_o),    32'(e_cg));
        chk("m_vgnt",   32'(vlsu_data_gnt_o),    32'(e_vg));
        chk("m_crv",    32'(core_data_rvalid_o), 32'(ecr));
        chk("m_vrv",    32'(vlsu_data_rvalid_o), 32'(evr));
        chk("m_spur",   32'(spurious_rsp_o),     32'(esp));
        chk("m_crdata", core_data_rdata_o,       data_rdata_i);
        chk("m_vrdata", vlsu_data_rdata_o,       data_rdata_i);
        if (n_reset) begin
            if (data_rvalid_i && q.size() > 0) void'(q.pop_front());
            if (hs) begin
                q.push_back(who);
                m_last   = who;
                m_locked = 0;
            end else if (ereq && !m_locked) begin
                m_locked = 1;
                m_owner  = who;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        sample();
        tick();
        n_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        sample();
        chk("rst_req",   32'(data_req_o),        0);
        chk("rst_rdata", core_data_rdata_o,      32'h1234_5678);
        tick();
        n_reset = 1'b1;

        // Core-only load with zero-latency grant, response next cycle
        core_data_req_i = 1; core_data_addr_i = 32'h100; data_gnt_i = 1;
        sample();
        chk("ld_cgnt", 32'(core_data_gnt_o), 1);
        chk("ld_addr", data_addr_o, 32'h100);
        tick();
        core_data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hDEADBEEF;
        sample();
        chk("ld_crv",   32'(core_data_rvalid_o), 1);
        chk("ld_rdata", core_data_rdata_o, 32'hDEADBEEF);
        chk("ld_vrv",   32'(vlsu_data_rvalid_o), 0);
        tick();
        data_rvalid_i = 0;

        // Simultaneous requests from reset: core first, then vlsu; in-order responses
        do_reset();
        core_data_req_i = 1; core_data_addr_i = 32'h200;
        vlsu_data_req_i = 1; vlsu_data_addr_i = 32'h300; data_gnt_i = 1;
        sample();
        chk("rr_cgnt", 32'(core_data_gnt_o), 1);
        chk("rr_vgnt", 32'(vlsu_data_gnt_o), 0);
        tick();
        core_data_req_i = 0;
        sample();
        chk("rr_vgnt2", 32'(vlsu_data_gnt_o), 1);
        chk("rr_addr2", data_addr_o, 32'h300);
        tick();
        vlsu_data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
        sample();
        chk("rr_crv", 32'(core_data_rvalid_o), 1);
        tick();
        sample();
        chk("rr_vrv", 32'(vlsu_data_rvalid_o), 1);
        tick();
        data_rvalid_i = 0;

        // Held vlsu request must not be displaced by a later core request
        vlsu_data_req_i = 1; vlsu_data_addr_i = 32'h400;
        sample();
        tick();
        core_data_req_i = 1; core_data_addr_i = 32'h500;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("lk_addr", data_addr_o, 32'h400);
            chk("lk_cgnt", 32'(core_data_gnt_o), 0);
            tick();
        end
        data_gnt_i = 1;
        sample();
        chk("lk_vgnt", 32'(vlsu_data_gnt_o), 1);
        tick();
        vlsu_data_req_i = 0;
        sample();
        chk("lk_cgnt2", 32'(core_data_gnt_o), 1);
        tick();
        core_data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
        sample();
        chk("lk_vrv", 32'(vlsu_data_rvalid_o), 1);
        tick();
        sample();
        chk("lk_crv", 32'(core_data_rvalid_o), 1);
        tick();
        data_rvalid_i = 0;

        // Outstanding limit, push blocked when full, push+pop at occupancy 1
        core_data_req_i = 1; core_data_addr_i = 32'h600; data_gnt_i = 1;
        sample(); tick();
        core_data_addr_i = 32'h604;
        sample(); tick();
        core_data_addr_i = 32'h608;
        sample();
        chk("full_req",  32'(data_req_o), 0);
        chk("full_cgnt", 32'(core_data_gnt_o), 0);
        tick();
        data_rvalid_i = 1;
        sample();
        chk("full_pop_req", 32'(data_req_o), 0);
        chk("full_pop_crv", 32'(core_data_rvalid_o), 1);
        tick();
        sample();
        chk("pp_cgnt", 32'(core_data_gnt_o), 1);
        chk("pp_crv",  32'(core_data_rvalid_o), 1);
        tick();
        core_data_addr_i = 32'h60C; data_rvalid_i = 0;
        sample();
        chk("pp_cgnt2", 32'(core_data_gnt_o), 1);
        tick();
        core_data_addr_i = 32'h610;
        sample();
        chk("pp_full", 32'(data_req_o), 0);
        tick();
        core_data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
        sample(); tick();
        sample(); tick();
        sample();
        chk("sp_pulse", 32'(spurious_rsp_o), 1);
        chk("sp_crv",   32'(core_data_rvalid_o), 0);
        chk("sp_vrv",   32'(vlsu_data_rvalid_o), 0);
        tick();
        data_rvalid_i = 0;
        sample();
        chk("sp_clear", 32'(spurious_rsp_o), 0);
        tick();

        // Asynchronous reset with one outstanding transaction
        core_data_req_i = 1; core_data_addr_i = 32'h700; data_gnt_i = 1;
        sample();
        tick();
        core_data_addr_i = 32'h704; data_rvalid_i = 1; data_rdata_i = 32'hCAFE_0001;
        #2;
        n_reset = 0;
        #1;
        chk("ar_req",   32'(data_req_o), 0);
        chk("ar_addr",  data_addr_o, 0);
        chk("ar_cgnt",  32'(core_data_gnt_o), 0);
        chk("ar_crv",   32'(core_data_rvalid_o), 0);
        chk("ar_spur",  32'(spurious_rsp_o), 0);
        chk("ar_rdata", vlsu_data_rdata_o, 32'hCAFE_0001);
        sample();
        tick();
        n_reset = 1; core_data_req_i = 0; data_gnt_i = 0;
        sample();
        chk("ar_post_spur", 32'(spurious_rsp_o), 1);
        chk("ar_post_crv",  32'(core_data_rvalid_o), 0);
        tick();
        data_rvalid_i = 0;

        // Randomized traffic; an ungranted request is held stable until granted
        for (int i = 0; i < 3000; i++) begin
            if (!(core_data_req_i && !e_cg)) begin
                core_data_req_i   = ($urandom_range(0, 99) < 45);
                core_data_we_i    = 1'($urandom);
                core_data_addr_i  = $urandom;
                core_data_wdata_i = $urandom;
                core_data_be_i    = 4'($urandom);
            end
            if (!(vlsu_data_req_i && !e_vg)) begin
                vlsu_data_req_i   = ($urandom_range(0, 99) < 45);
                vlsu_data_we_i    = 1'($urandom);
                vlsu_data_addr_i  = $urandom;
                vlsu_data_wdata_i = $urandom;
                vlsu_data_be_i    = 4'($urandom);
            end
            data_gnt_i    = ($urandom_range(0, 99) < 60);
            data_rvalid_i = ($urandom_range(0, 99) < 40);
            data_rdata_i  = $urandom;
            n_reset       = ($urandom_range(0, 299) != 0);
            sample();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
